// File: rtl/gf2m_eea_inverter.sv
// GF(2^M) inverter using the extended binary Euclidean algorithm, one iteration per clock (2M cycles).
// Optional macro GF_INV_ZERO_DETECT_EN: a zero operand completes in one cycle with err_o=1.
module gf2m_eea_inverter #(
  parameter int         M    = 7,
  parameter logic [M:0] POLY = 8'b10111111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [M-1:0] a_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [M-1:0] inv_o,
  output logic         err_o
);

  // state   | meaning
  // IDLE    | waiting for start_i; outputs hold last result
  // RUN     | one Euclidean iteration per cycle, 2M cycles
  // ZERO    | zero operand seen, completes with err_o next edge
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  localparam int             DW   = $clog2(M + 1) + 1;
  localparam int             CW   = $clog2(2 * M + 1);
  localparam logic [M-1:0]   FL   = POLY[M-1:0];
  localparam logic [CW-1:0]  LAST = CW'(2 * M - 1);

  state_t          r_state, w_state_nxt;
  logic [M:0]      r_r, r_s, w_r_nxt, w_s_nxt;
  logic [M-1:0]    r_u, r_v, w_u_nxt, w_v_nxt;
  logic [DW-1:0]   r_delta, w_delta_nxt;
  logic [CW-1:0]   r_ctr, w_ctr_nxt;
  logic            r_busy, r_done, r_err;
  logic            w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [M-1:0]    r_inv, w_inv_nxt;

  logic [M:0]      w_r_it, w_s_it, w_s_sel, w_s_sh;
  logic [M-1:0]    w_u_it, w_v_it, w_v_sel;
  logic [DW-1:0]   w_delta_it;

  function automatic logic [M-1:0] mul_x(input logic [M-1:0] u);
    mul_x = {u[M-2:0], 1'b0} ^ (u[M-1] ? FL : '0);
  endfunction

  // FL[0]=1, so with u[0]=1 the low bit of u^FL is zero and the shift is exact.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] u);
    logic [M-1:0] t;
    t = u ^ FL;
    div_x = u[0] ? {1'b1, t[M-1:1]} : {1'b0, u[M-1:1]};
  endfunction

  always_comb begin
    w_s_sel    = r_s[M] ? (r_s ^ r_r) : r_s;
    w_v_sel    = r_s[M] ? (r_v ^ r_u) : r_v;
    w_s_sh     = {w_s_sel[M-1:0], 1'b0};
    w_r_it     = r_r;
    w_s_it     = r_s;
    w_u_it     = r_u;
    w_v_it     = r_v;
    w_delta_it = r_delta;
    if (!r_r[M]) begin
      w_r_it     = {r_r[M-1:0], 1'b0};
      w_u_it     = mul_x(r_u);
      w_delta_it = r_delta + DW'(1);
    end else if (r_delta == '0) begin
      w_r_it     = w_s_sh;
      w_s_it     = r_r;
      w_u_it     = mul_x(w_v_sel);
      w_v_it     = r_u;
      w_delta_it = DW'(1);
    end else begin
      w_s_it     = w_s_sh;
      w_v_it     = w_v_sel;
      w_u_it     = div_x(r_u);
      w_delta_it = r_delta - DW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_r_nxt     = r_r;
    w_s_nxt     = r_s;
    w_u_nxt     = r_u;
    w_v_nxt     = r_v;
    w_delta_nxt = r_delta;
    w_ctr_nxt   = r_ctr;
    w_done_nxt  = 1'b0;
    w_inv_nxt   = r_inv;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
`ifdef GF_INV_ZERO_DETECT_EN
          if (a_i == '0) begin
            w_state_nxt = ST_ZERO;
          end else
`endif
          begin
            w_state_nxt = ST_RUN;
            w_r_nxt     = {1'b0, a_i};
            w_s_nxt     = POLY;
            w_u_nxt     = M'(1);
            w_v_nxt     = '0;
            w_delta_nxt = '0;
            w_ctr_nxt   = '0;
          end
        end
      end
      ST_RUN: begin
        w_r_nxt     = w_r_it;
        w_s_nxt     = w_s_it;
        w_u_nxt     = w_u_it;
        w_v_nxt     = w_v_it;
        w_delta_nxt = w_delta_it;
        w_ctr_nxt   = r_ctr + CW'(1);
        if (r_ctr == LAST) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_inv_nxt   = w_u_it;
          w_err_nxt   = 1'b0;
        end
      end
      ST_ZERO: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        w_inv_nxt   = '0;
        w_err_nxt   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_r     <= '0;
      r_s     <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_delta <= '0;
      r_ctr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_inv   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_r     <= w_r_nxt;
      r_s     <= w_s_nxt;
      r_u     <= w_u_nxt;
      r_v     <= w_v_nxt;
      r_delta <= w_delta_nxt;
      r_ctr   <= w_ctr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_inv   <= w_inv_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign inv_o  = r_inv;
  assign err_o  = r_err;

endmodule

// File: tb/tb_gf2m_eea_inverter.sv
// Directed bench for gf2m_eea_inverter: M=7 default field plus an M=8 AES-field instance.
module tb_gf2m_eea_inverter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] a = '0;
  logic       busy, done, err;
  logic [6:0] inv;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic       busy8, done8, err8;
  logic [7:0] inv8;

  int n_checks = 0;
  int n_fail   = 0;

  gf2m_eea_inverter #(.M(7), .POLY(8'b10111111)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a),
    .busy_o(busy), .done_o(done), .inv_o(inv), .err_o(err));

  gf2m_eea_inverter #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8),
    .busy_o(busy8), .done_o(done8), .inv_o(inv8), .err_o(err8));

  always #5 clk = ~clk;

  // Reference multiply in GF(2^7), F = x^7+x^5+x^4+x^3+x^2+x+1.
  function automatic logic [6:0] gmul7(input logic [6:0] x, input logic [6:0] y);
    logic [6:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 7; i++) begin
      if (y[i]) p = p ^ t;
      t = t[6] ? ({t[5:0], 1'b0} ^ 7'h3F) : {t[5:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [6:0] ginv7(input logic [6:0] x);
    logic [6:0] r;
    r = '0;
    for (int b = 1; b < 128; b++)
      if (gmul7(x, 7'(b)) == 7'h01) r = 7'(b);
    return r;
  endfunction

  // Starts one M=7 operation and waits (bounded) for done_o; lat=0 means it never came.
  task automatic do_run(input logic [6:0] av, input bit poke, output int lat,
                        output logic [6:0] res, output logic e_res, output logic b_acc,
                        output logic d_acc, output logic [6:0] inv_mid);
    lat = 0; res = '0; e_res = 1'b0; inv_mid = '0;
    @(negedge clk);
    start = 1'b1; a = av;
    @(posedge clk); #1;
    b_acc = busy; d_acc = done;
    start = 1'b0; a = 7'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) inv_mid = inv;
      if (done) begin
        lat = c; res = inv; e_res = err;
        break;
      end
      if (poke && c == 4) begin start = 1'b1; a = 7'($urandom); end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (inv !== 7'h00) begin n_fail++; $display("FAIL reset_inv: got %h expected 00", inv); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (inv8 !== 8'h00) begin n_fail++; $display("FAIL reset_inv8: got %h expected 00", inv8); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [6:0] res, mid; logic e, b, d;
    do_run(7'h01, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_accept: got %b expected 1", b); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL basic_latency: got %0d expected 14", lat); end
    n_checks++; if (res !== 7'h01) begin n_fail++; $display("FAIL basic_inv_01: got %h expected 01", res); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", e); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++; if (inv !== 7'h01) begin n_fail++; $display("FAIL basic_inv_hold: got %h expected 01", inv); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [6:0] res, mid; logic e, b, d;
    do_run(7'h02, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 14", lat); end
    n_checks++; if (res !== 7'h5F) begin n_fail++; $display("FAIL b2b_inv_02: got %h expected 5f", res); end
    // Called straight from the done cycle: accept lands 15 edges after the first accept.
    do_run(7'h5F, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b expected 1", b); end
    n_checks++; if (d !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", d); end
    n_checks++; if (mid !== 7'h5F) begin n_fail++; $display("FAIL b2b_inv_held: got %h expected 5f", mid); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected 14", lat); end
    n_checks++; if (res !== 7'h02) begin n_fail++; $display("FAIL b2b_inv_5f: got %h expected 02", res); end
  endtask

  task automatic test_exhaustive();
    int lat; logic [6:0] res, mid, expv, prev; logic e, b, d;
    prev = 7'h02;
    for (int i = 1; i < 128; i++) begin
      expv = ginv7(7'(i));
      do_run(7'(i), 1'b1, lat, res, e, b, d, mid);
      n_checks++; if (lat != 14) begin n_fail++; $display("FAIL exh_latency a=%h: got %0d expected 14", i, lat); end
      n_checks++; if (res !== expv) begin n_fail++; $display("FAIL exh_inv a=%h: got %h expected %h", i, res, expv); end
      n_checks++; if (gmul7(7'(i), res) !== 7'h01) begin n_fail++; $display("FAIL exh_product a=%h: got %h expected 01", i, gmul7(7'(i), res)); end
      n_checks++; if (mid !== prev) begin n_fail++; $display("FAIL exh_inv_held a=%h: got %h expected %h", i, mid, prev); end
      @(posedge clk); #1;
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL exh_idle_after a=%h: got %b expected 00", i, {busy, done}); end
      prev = expv;
    end
  endtask

  task automatic test_reset_midrun();
    int lat, ndone; logic [6:0] res, mid; logic e, b, d;
    @(negedge clk); start = 1'b1; a = 7'h03;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (inv !== 7'h00) begin n_fail++; $display("FAIL midrst_inv: got %h expected 00", inv); end
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL midrst_done_err: got %b expected 00", {done, err}); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone); end
    do_run(7'h02, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 14", lat); end
    n_checks++; if (res !== 7'h5F) begin n_fail++; $display("FAIL midrst_inv_after: got %h expected 5f", res); end
  endtask

  task automatic test_zero();
    int lat; logic [6:0] res, mid; logic e, b, d;
    do_run(7'h00, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL zero_busy_at_accept: got %b expected 1", b); end
`ifdef GF_INV_ZERO_DETECT_EN
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    n_checks++; if (res !== 7'h00) begin n_fail++; $display("FAIL zero_inv: got %h expected 00", res); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %b expected 1", e); end
`else
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL zero_latency: got %0d expected 14", lat); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b expected 0", e); end
`endif
    do_run(7'h01, 1'b0, lat, res, e, b, d, mid);
    n_checks++; if (res !== 7'h01) begin n_fail++; $display("FAIL zero_next_inv: got %h expected 01", res); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL zero_next_err: got %b expected 0", e); end
  endtask

  task automatic test_m8();
    int lat;
    logic [7:0] res;
    lat = 0; res = '0;
    @(negedge clk); start8 = 1'b1; a8 = 8'h53;
    @(posedge clk); #1; start8 = 1'b0; a8 = 8'h00;
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL m8_busy_at_accept: got %b expected 1", busy8); end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done8) begin lat = c; res = inv8; break; end
    end
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL m8_latency: got %0d expected 16", lat); end
    n_checks++; if (res !== 8'hCA) begin n_fail++; $display("FAIL m8_inv_53: got %h expected ca", res); end
    n_checks++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL m8_err: got %b expected 0", err8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_exhaustive();
    test_reset_midrun();
    test_zero();
    test_m8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/gf2m_eea_inverter.md
# gf2m_eea_inverter

Parametrised, single-clock GF(2^M) inverter built on the extended binary Euclidean algorithm: 2M iterations, one iteration per clock. Generalises the fixed GF(2^7) D-cell/M-cell array and its separate control-logic clock to any field width M and any irreducible polynomial, adding a start/done handshake, a busy flag and zero-operand detection. Sits between the operand register file and the point-arithmetic datapath.

## Interface
- M, 7, field degree (M ≥ 2)
- POLY, 8'b10111111, irreducible F(x), M+1 bits; POLY[M] = POLY[0] = 1. Default is x^7+x^5+x^4+x^3+x^2+x+1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request; accepted only when busy_o = 0
- a_i  in  M  operand; sampled only at the accepting edge
- busy_o  out  1  iteration in progress
- done_o  out  1  one-cycle pulse: inv_o/err_o updated this cycle
- inv_o  out  M  A^-1 mod F; held until next completion
- err_o  out  1  operand was zero (see Configuration); held with inv_o

## Operation
- State: R, S (M+1 bits), U, V (M bits), delta (clog2(M+1)+1 bits, unsigned), iteration counter ctr (clog2(2M+1) bits), FSM {IDLE, RUN}.
- IDLE, start_i=1: R={0,a_i}, S=POLY, U=1, V=0, delta=0, ctr=0 → RUN. start_i ignored in RUN.
- Modular ops (Fl=POLY[M-1:0]): xU = (U<<1)[M-1:0] ^ (U[M-1] ? Fl : 0); U/x = U[0] ? ((U^Fl)>>1) | 1<<(M-1) : U>>1.
- Each RUN cycle, from current values:
  - R[M]=0: R=R<<1 (M+1 bits), U=xU, delta=delta+1.
  - R[M]=1: S'=S[M] ? S^R : S, V'=S[M] ? V^U : V; S'=S'<<1.
    - delta=0: R←S', S←R, U←x·V', V←U, delta=1.
    - delta≠0: S←S', V←V', U←U/x, delta=delta−1.
- ctr increments each RUN cycle; on the cycle ctr=2M−1 the final iteration is applied, inv_o←final U, err_o←0, done_o=1 for that cycle, FSM→IDLE.
- Reset (any time, including mid-RUN): FSM=IDLE, busy_o=0, done_o=0, inv_o=0, err_o=0, internal registers 0; in-flight operation discarded, no done_o.

## Timing
- Accept edge k: load; busy_o=1 from k. Iteration i (1..2M) at edge k+i.
- Edge k+2M: inv_o valid, done_o=1, busy_o=0 (same edge). Latency 2M cycles (14 at M=7).
- done_o deasserts at edge k+2M+1 unless a new start completes there (impossible; min period 2M+1 cycles).
- start_i high during done_o cycle: accepted at edge k+2M+1 (back-to-back, throughput one result per 2M+1 cycles).
- inv_o/err_o change only at completion edges and reset.

## Configuration
- GF_INV_ZERO_DETECT_EN defined: a_i=0 at accept → no RUN; next edge inv_o=0, err_o=1, done_o=1 (busy_o high one cycle, latency 1).
- Undefined: no zero check; a_i=0 runs the full 2M cycles, inv_o unspecified (bench must not check), err_o tied 0.

## Test plan
- M=7 default POLY: a_i=0x01 → after 14 cycles done_o pulse, inv_o=0x01, err_o=0.
- a_i=0x02 → inv_o=0x5F; then back-to-back start in done cycle with a_i=0x5F → inv_o=0x02, 15 cycles after the first accept edge.
- Exhaustive 1..127: each result checked by golden model, a·inv mod F = 1; start_i pulsed during busy_o ignored (no extra done_o).
- rst_n low at iteration 6 of a run → all outputs 0 immediately, no done_o; new start after release gives correct result.
- a_i=0 with GF_INV_ZERO_DETECT_EN → done_o one cycle after accept, inv_o=0, err_o=1; without macro → done_o after 14 cycles, err_o=0.
- M=8, POLY=9'h11B: a_i=0x53 → inv_o=0xCA after 16 cycles.
